// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and fetches one instruction per core instruction.
// A fetch is requested over a valid/ready channel and completed by a response strobe.
// When the core reaches COMMIT_STATE, the next PC is chosen from three sources:
// the sequential PC, a branch/JAL target, or a JALR target.
// A control-flow target that is not word aligned freezes the unit.
// It stays frozen until reset.
//
// Ports
//   clk, resetn          core clock, asynchronous active-low reset
//   state                core FSM state; a commit is taken when it equals COMMIT_STATE
//   taken_branch         registered branch/jump decision
//   is_jal, is_jalr      instruction class from decode
//   imm, rs1_val         sign-extended immediate, rs1 operand for JALR
//   fetch_valid/ready    fetch request handshake, fetch_addr = pc
//   fetch_rvalid/rdata   fetch response
//   pc, pc_plus4         current PC and link value
//   instr, instr_valid   latched instruction and its one-cycle update pulse
//   misaligned, mis_addr sticky misaligned-target flag and the offending target
//
// FSM
//   state | meaning
//   REQ   | request outstanding at pc, waiting for fetch_ready
//   WAIT  | request accepted, waiting for fetch_rvalid
//   HOLD  | instruction latched, waiting for the commit state
//   HALT  | misaligned target seen, frozen until reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [2:0]  COMMIT_STATE = 3'd5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  state,
    input  logic        taken_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        fetch_ready,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] mis_addr
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} fsm_t;

    fsm_t        r_fsm;
    fsm_t        w_fsm_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_mis;
    logic [31:0] r_mis_addr;

    logic        w_taken;
    logic        w_commit;
    logic        w_accept;
    logic        w_resp;
    logic [31:0] w_target;

    // A JAL redirects only through taken_branch. is_jal by itself never forces a jump.
    assign w_taken  = taken_branch | (taken_branch & is_jal);
    assign w_commit = (r_fsm == S_HOLD) && (state == COMMIT_STATE);
    assign w_accept = (r_fsm == S_REQ) && fetch_ready;
    assign w_resp   = (r_fsm == S_WAIT) && fetch_rvalid;

    always_comb begin
        w_target = r_pc + 32'd4;
        if (is_jalr)
            w_target = (rs1_val + imm) & ~32'h1;
        else if (w_taken)
            w_target = r_pc + imm;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_fsm <= S_REQ;
        else
            r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_REQ:   if (fetch_ready)  w_fsm_nxt = S_WAIT;
            S_WAIT:  if (fetch_rvalid) w_fsm_nxt = S_HOLD;
            S_HOLD:  if (w_commit)     w_fsm_nxt = w_target[1] ? S_HALT : S_REQ;
            default: w_fsm_nxt = S_HALT;
        endcase
    end

    // The request is gated by resetn so that fetch_valid reads 0 while reset is held,
    // even though the FSM already sits in REQ.
    always_comb begin
        fetch_valid = 1'b0;
        if (r_fsm == S_REQ)
            fetch_valid = resetn;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_mis         <= 1'b0;
            r_mis_addr    <= 32'h0;
        end else begin
            r_instr_valid <= w_resp;
            if (w_resp)
                r_instr <= fetch_rdata;
            if (w_commit) begin
                if (w_target[1]) begin
                    r_mis      <= 1'b1;
                    r_mis_addr <= w_target;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign fetch_addr  = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign misaligned  = r_mis;
    assign mis_addr    = r_mis_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  state = 3'd0;
    logic        taken_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        fetch_ready = 1'b0;
    logic        fetch_rvalid = 1'b0;
    logic [31:0] fetch_rdata = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;
    logic [31:0] mis_addr;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .COMMIT_STATE(3'd5)) dut (
        .clk(clk), .resetn(resetn), .state(state), .taken_branch(taken_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .rs1_val(rs1_val),
        .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .instr_valid(instr_valid), .misaligned(misaligned), .mis_addr(mis_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle and matches every presented request/response
    // against the scoreboard queues filled by the stimulus process.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (fetch_valid) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_fetch: addr %h with no request expected at %0t", fetch_addr, $time);
                    end else begin
                        chk("fetch_addr", fetch_addr, exp_addr_q[0]);
                        if (fetch_ready) void'(exp_addr_q.pop_front());
                    end
                end
                if (instr_valid) begin
                    if (exp_instr_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_instr_valid: instr %h with no response expected at %0t", instr, $time);
                    end else begin
                        chk("instr", instr, exp_instr_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        fetch_ready = 1'b0;
        fetch_rvalid = 1'b0;
        state = 3'd0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        #1;
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_mis_addr", mis_addr, 32'h0);
        step();
        step();
        m_pc = RESET_PC;
        exp_addr_q.push_back(m_pc);
        resetn = 1'b1;
    endtask

    // One fetch: bp cycles of backpressure, a response lat cycles after acceptance.
    task automatic do_fetch(input int bp, input int lat, input logic [31:0] data);
        fetch_ready = 1'b0;
        repeat (bp) step();
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        chk("accept_count", exp_addr_q.size(), 32'd0);
        exp_addr_q.delete();
        repeat (lat - 1) step();
        fetch_rvalid = 1'b1;
        fetch_rdata = data;
        exp_instr_q.push_back(data);
        step();
        fetch_rvalid = 1'b0;
        fetch_rdata = $urandom;
        step();
        chk("instr_valid_count", exp_instr_q.size(), 32'd0);
        exp_instr_q.delete();
    endtask

    task automatic commit(input logic jr, input logic tk, input logic jl,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v, input int hold);
        logic [31:0] tgt;
        chk("pc_before_commit", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        if (jr)      tgt = (rs1_v + imm_v) & 32'hFFFF_FFFE;
        else if (tk) tgt = m_pc + imm_v;
        else         tgt = m_pc + 32'd4;
        is_jalr = jr; taken_branch = tk; is_jal = jl; imm = imm_v; rs1_val = rs1_v;
        state = 3'd5;
        if (tgt[1] == 1'b0) begin
            m_pc = tgt;
            exp_addr_q.push_back(tgt);
        end
        repeat (hold) step();
        state = 3'd0;
        is_jalr = 1'b0; taken_branch = 1'b0; is_jal = 1'b0;
        if (tgt[1] == 1'b1) begin
            chk("misaligned", {31'h0, misaligned}, 32'h1);
            chk("mis_addr", mis_addr, tgt);
            fetch_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                chk("halt_no_fetch", {31'h0, fetch_valid}, 32'h0);
                step();
            end
            fetch_ready = 1'b0;
            chk("halt_misaligned", {31'h0, misaligned}, 32'h1);
            chk("halt_pc", pc, m_pc);
            do_reset();
        end else begin
            chk("commit_pc", pc, tgt);
        end
    endtask

    initial begin
        int r, k;
        logic [31:0] v, w;
        m_pc = RESET_PC;
        do_reset();

        // Reset release, first fetch at 0, then a sequential commit to 0x4.
        do_fetch(0, 1, 32'h0000_0013);
        commit(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1);
        do_fetch(0, 1, 32'h1234_5678);
        commit(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1);
        // Branch backwards from 0x100 by -8.
        do_fetch(1, 2, 32'hAAAA_0001);
        commit(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1);
        chk("branch_no_mis", {31'h0, misaligned}, 32'h0);
        do_fetch(0, 1, 32'hAAAA_0002);
        commit(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1);
        // JALR from 0x40: bit 0 of the target is cleared, and the commit state is held for 2 cycles.
        do_fetch(0, 1, 32'hAAAA_0003);
        commit(1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_2001, 2);
        // Wrap past the top of the address space.
        do_fetch(3, 1, 32'hAAAA_0004);
        commit(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1);
        do_fetch(0, 3, 32'hAAAA_0005);
        commit(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
        chk("wrap_pc", pc, 32'h0000_0000);
        do_fetch(0, 1, 32'hAAAA_0006);
        commit(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1);
        // Misaligned branch from 0x100 to 0x102.
        do_fetch(0, 1, 32'hAAAA_0007);
        commit(1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 1);

        // Reset while in WAIT, followed by a stale response after release.
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        exp_addr_q.delete();
        step();
        do_reset();
        fetch_rvalid = 1'b1;
        fetch_rdata = 32'hDEAD_BEEF;
        step();
        fetch_rvalid = 1'b0;
        step();
        chk("stale_instr", instr, 32'h0);
        do_fetch(2, 1, 32'h0000_0093);
        commit(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1);

        for (int it = 0; it < 200; it++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            repeat ($urandom_range(0, 2)) step();
            r = $urandom_range(0, 9);
            if (r < 4) begin
                commit(1'b0, 1'b0, r[0], $urandom, $urandom, $urandom_range(1, 2));
            end else if (r < 7) begin
                k = $urandom_range(0, 511);
                v = 32'(k - 256) << 2;
                commit(1'b0, 1'b1, r[0], v, $urandom, $urandom_range(1, 2));
            end else if (r < 9) begin
                v = $urandom;
                w = $urandom_range(0, 255);
                commit(1'b1, r[0], 1'b0, w, v, $urandom_range(1, 2));
            end else begin
                k = $urandom_range(0, 63);
                v = (32'(k - 32) << 2) | 32'h2;
                commit(1'b0, 1'b1, 1'b0, v, $urandom, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
